// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex display driver: segment table, blank pattern, counter sizing.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package hex_disp_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Active-low patterns, bit6 = g .. bit0 = a, indexed by nibble value 0..F.
    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1011000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // Width of a counter that must hold 0..div-1; never narrower than one bit.
    function automatic int ctr_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Maps one hex nibble to its active-low 7-segment pattern.
// Latency: purely combinational.
// Backpressure: none.
module seg7_encode
    import hex_disp_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment driver: latched value, leading-zero blanking, per-digit blink, optional scan mux.
// Latency: LOAD sample edge captures the value, the next edge registers HEX/DIG_EN (2 edges total).
// Backpressure: none; LOAD is accepted every cycle and simply overwrites the held value.
module hex_display_driver
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_EN    = 0,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        LOAD,
    input  logic [4*NUM_DIGITS-1:0]     VALUE,
    input  logic                        BLANK_LZ,
    input  logic [NUM_DIGITS-1:0]       BLINK_EN,
    output logic [SEG_W*NUM_DIGITS-1:0] HEX,
    output logic [NUM_DIGITS-1:0]       DIG_EN
);

    localparam int BW = ctr_width(BLINK_DIV);
    localparam int SW = ctr_width(SCAN_DIV);
    localparam int IW = ctr_width(NUM_DIGITS);

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0]     val_q;
    logic                        loaded_q;
    logic [BW-1:0]               blink_cnt;
    logic                        blink_hidden;
    logic [SW-1:0]               scan_cnt;
    logic [IW-1:0]               scan_idx;
    logic [SEG_W*NUM_DIGITS-1:0] raw_seg;
    logic [SEG_W*NUM_DIGITS-1:0] fin_seg;
    logic [NUM_DIGITS:0]         zero_from;
    logic [SEG_W-1:0]            scan_pat;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
        seg7_encode u_enc (
            .nib (val_q[4*gi +: 4]),
            .seg (raw_seg[SEG_W*gi +: SEG_W])
        );
    end

    // Hold the displayed value; loaded_q keeps the display dark until the first LOAD after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            val_q    <= '0;
            loaded_q <= 1'b0;
        end else if (LOAD) begin
            val_q    <= VALUE;
            loaded_q <= 1'b1;
        end
    end

    // Free-running blink prescaler; LOAD restarts it visible so fresh data is never shown hidden.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (LOAD) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BW'(1);
        end
    end

    // Scan prescaler and digit index; parked at zero when driving all digits in parallel.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (SCAN_EN != 0) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end else begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end
    end

    // Final per-digit pattern: leading-zero, blink and not-yet-loaded blanking all OR together.
    always_comb begin
        zero_from             = '0;
        fin_seg               = '1;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (val_q[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!loaded_q
                || (BLANK_LZ && (i != 0) && zero_from[i])
                || (blink_hidden && BLINK_EN[i])) begin
                fin_seg[SEG_W*i +: SEG_W] = SEG_BLANK;
            end else begin
                fin_seg[SEG_W*i +: SEG_W] = raw_seg[SEG_W*i +: SEG_W];
            end
        end
    end

    // Pick the pattern of the currently scanned digit.
    always_comb begin
        scan_pat = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                scan_pat = fin_seg[SEG_W*i +: SEG_W];
            end
        end
    end

    // Output registers: parallel drive of every slice, or the scanned digit on slot 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            HEX    <= '1;
            DIG_EN <= '1;
        end else if (SCAN_EN != 0) begin
            HEX          <= '1;
            HEX[SEG_W-1:0] <= scan_pat;
            DIG_EN       <= ~(NUM_DIGITS'(1) << scan_idx);
        end else begin
            HEX    <= fin_seg;
            DIG_EN <= '0;
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver: one parallel and one scanning instance share stimulus.
// Latency: expectations account for the 2-edge LOAD-to-HEX path.
// Backpressure: none.
module tb_hex_display_driver;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0]  BLK     = 7'b1111111;
    localparam logic [27:0] ALL_OFF = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  blink_en;
    logic [27:0] hex_p, hex_s;
    logic [3:0]  dig_p, dig_s;

    int checks = 0;
    int errors = 0;

    logic [15:0] mv;
    logic        mld, mhid;
    int          mcnt;
    logic [27:0] exp_hex;

    always #5 clk = ~clk;

    hex_display_driver #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN_EN(0), .SCAN_DIV(2)) u_par (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .BLANK_LZ(blank_lz),
        .BLINK_EN(blink_en), .HEX(hex_p), .DIG_EN(dig_p)
    );

    hex_display_driver #(.NUM_DIGITS(4), .BLINK_DIV(4), .SCAN_EN(1), .SCAN_DIV(2)) u_scan (
        .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .BLANK_LZ(blank_lz),
        .BLINK_EN(blink_en), .HEX(hex_s), .DIG_EN(dig_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference display: blank everything above the highest non-zero digit when LZ is on.
    function automatic logic [27:0] model_hex(input logic [15:0] v, input logic ld,
                                              input logic hid, input logic lz,
                                              input logic [3:0] be);
        logic [27:0] r;
        logic [6:0]  s;
        int          top;
        top = 0;
        for (int k = 0; k < 4; k++) if (v[4*k +: 4] != 4'h0) top = k;
        for (int d = 0; d < 4; d++) begin
            s = SEG[v[4*d +: 4]];
            if (!ld) s = BLK;
            if (lz && d > top) s = BLK;
            if (hid && be[d]) s = BLK;
            r[7*d +: 7] = s;
        end
        return r;
    endfunction

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; blink_en = '0;
        tick();
        tick();
        chk("reset_hex", {4'b0, hex_p}, {4'b0, ALL_OFF});
        chk("reset_dig", {28'b0, dig_p}, 32'hF);
        chk("reset_scan_dig", {28'b0, dig_s}, 32'hF);
        rst = 1'b0;
        tick();
        chk("idle_dig", {28'b0, dig_p}, 32'h0);
        chk("idle_hex", {4'b0, hex_p}, {4'b0, ALL_OFF});

        // Basic load and 2-edge latency.
        value = 16'h1A3F; load = 1'b1;
        tick();
        load = 1'b0;
        chk("load_lat1", {4'b0, hex_p}, {4'b0, ALL_OFF});
        tick();
        chk("load_1a3f", {4'b0, hex_p}, {4'b0, SEG[1], SEG[10], SEG[3], SEG[15]});
        chk("load_dig", {28'b0, dig_p}, 32'h0);

        // Leading-zero blanking.
        blank_lz = 1'b1; value = 16'h0000; load = 1'b1;
        tick(); load = 1'b0; tick();
        chk("lz_0000", {4'b0, hex_p}, {4'b0, BLK, BLK, BLK, SEG[0]});
        value = 16'h0100; load = 1'b1;
        tick(); load = 1'b0; tick();
        chk("lz_0100", {4'b0, hex_p}, {4'b0, BLK, SEG[1], SEG[0], SEG[0]});
        blank_lz = 1'b0;
        tick();
        chk("lz_off_level", {4'b0, hex_p}, {4'b0, SEG[0], SEG[1], SEG[0], SEG[0]});
        blank_lz = 1'b1; value = 16'h1002; load = 1'b1;
        tick(); load = 1'b0; tick();
        chk("lz_internal", {4'b0, hex_p}, {4'b0, SEG[1], SEG[0], SEG[0], SEG[2]});

        // Blink on digits 0 and 2: 4 visible, 4 hidden, then a LOAD on the terminal edge.
        blank_lz = 1'b0; blink_en = 4'b0101; value = 16'h8888; load = 1'b1;
        tick();
        load = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            tick();
            if (j <= 4 || j >= 9)
                chk($sformatf("blink_vis_%0d", j), {4'b0, hex_p}, {4'b0, SEG[8], SEG[8], SEG[8], SEG[8]});
            else
                chk($sformatf("blink_hid_%0d", j), {4'b0, hex_p}, {4'b0, SEG[8], BLK, SEG[8], BLK});
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("blink_reload", {4'b0, hex_p}, {4'b0, SEG[8], SEG[8], SEG[8], SEG[8]});
        for (int j = 1; j <= 5; j++) begin
            tick();
            if (j <= 4)
                chk($sformatf("reload_vis_%0d", j), {4'b0, hex_p}, {4'b0, SEG[8], SEG[8], SEG[8], SEG[8]});
            else
                chk("reload_hid", {4'b0, hex_p}, {4'b0, SEG[8], BLK, SEG[8], BLK});
        end

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hex", {4'b0, hex_p}, {4'b0, ALL_OFF});
        chk("arst_dig", {28'b0, dig_p}, 32'hF);
        chk("arst_scan_hex", {4'b0, hex_s}, {4'b0, ALL_OFF});
        chk("arst_scan_dig", {28'b0, dig_s}, 32'hF);
        tick();
        rst = 1'b0; blink_en = '0; blank_lz = 1'b0; value = 16'h4321;

        // Scan sequence alongside parallel "dark until LOAD" behaviour; LOAD sampled on edge 3.
        for (int n = 1; n <= 12; n++) begin
            int d;
            tick();
            d = ((n - 1) / 2) % 4;
            chk($sformatf("scan_dig_%0d", n), {28'b0, dig_s}, {28'b0, ~(4'b0001 << d)});
            if (n >= 4) begin
                chk($sformatf("scan_hex_%0d", n), {4'b0, hex_s}, {4'b0, 21'h1FFFFF, SEG[d+1]});
                chk($sformatf("par_hex_%0d", n), {4'b0, hex_p}, {4'b0, SEG[4], SEG[3], SEG[2], SEG[1]});
            end else begin
                chk($sformatf("scan_dark_%0d", n), {4'b0, hex_s}, {4'b0, ALL_OFF});
                chk($sformatf("par_dark_%0d", n), {4'b0, hex_p}, {4'b0, ALL_OFF});
            end
            chk($sformatf("par_dig_%0d", n), {28'b0, dig_p}, 32'h0);
            if (n == 2) load = 1'b1;
            if (n == 3) load = 1'b0;
        end

        // Randomised traffic on the parallel instance against the reference model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mv = '0; mld = 1'b0; mhid = 1'b0; mcnt = 0;
        for (int c = 0; c < 300; c++) begin
            load     = ($urandom_range(0, 7) == 0);
            value    = 16'($urandom);
            blank_lz = 1'($urandom);
            blink_en = 4'($urandom);
            exp_hex  = model_hex(mv, mld, mhid, blank_lz, blink_en);
            if (load) begin
                mv = value; mld = 1'b1; mcnt = 0; mhid = 1'b0;
            end else if (mcnt == 3) begin
                mcnt = 0; mhid = ~mhid;
            end else begin
                mcnt++;
            end
            tick();
            chk("stress_hex", {4'b0, hex_p}, {4'b0, exp_hex});
            chk("stress_known", 32'($isunknown(hex_p)), 32'h0);
        end
        chk("stress_dig", {28'b0, dig_p}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
